// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the mini CPU.
// Owns pc, IR, the latched zero flag and the retired count. Has a run/step debug handshake.
module cpu_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] instr,
  input  logic       zero,
  input  logic       run,
  input  logic       step,
  output logic [3:0] pc,
  output logic [3:0] imm,
  output logic [2:0] alu_op,
  output logic       do_alu,
  output logic       we_a,
  output logic       we_b,
  output logic       busy,
  output logic       halted,
  output logic [7:0] retired
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALTED = 3'd5;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_LDB = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_HLT = 4'hF;

  logic [2:0] state, state_nxt;
  logic [7:0] ir;
  logic       z_flag;
  logic       step_d;
  logic       single;
  logic [3:0] opcode;
  logic [3:0] alu_idx;
  logic       is_alu;
  logic       take_jump;
  logic       in_op;

  assign opcode    = ir[7:4];
  assign imm       = ir[3:0];
  assign is_alu    = (opcode >= OP_ADD) && (opcode <= OP_OR);
  assign alu_idx   = opcode - OP_ADD;
  assign take_jump = (opcode == OP_JMP) || ((opcode == OP_JZ) && z_flag);

  // IR still holds the previous instruction during FETCH, so decode only from DECODE on.
  assign in_op  = (state == S_DECODE) || (state == S_EXEC) || (state == S_WB);
  assign alu_op = (in_op && is_alu) ? alu_idx[2:0] : 3'b000;
  assign do_alu = is_alu && ((state == S_EXEC) || (state == S_WB));
  assign we_a   = (state == S_WB) && ((opcode == OP_LDA) || is_alu);
  assign we_b   = (state == S_WB) && (opcode == OP_LDB);
  assign busy   = (state == S_FETCH) || in_op;
  assign halted = (state == S_HALTED);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (run || (step && !step_d)) state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC:   state_nxt = S_WB;
      S_WB: begin
        if (opcode == OP_HLT)     state_nxt = S_HALTED;
        else if (run && !single)  state_nxt = S_FETCH;
        else                      state_nxt = S_IDLE;
      end
      S_HALTED: state_nxt = S_HALTED;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc      <= 4'd0;
      ir      <= 8'd0;
      z_flag  <= 1'b0;
      retired <= 8'd0;
      step_d  <= 1'b0;
      single  <= 1'b0;
    end else begin
      state  <= state_nxt;
      step_d <= step;
      // run wins over step, so a launch with run high is never single-step.
      if (state == S_IDLE && state_nxt == S_FETCH) single <= !run;
      if (state == S_WB && state_nxt == S_IDLE)    single <= 1'b0;
      if (state == S_FETCH)          ir     <= instr;
      if (state == S_EXEC && is_alu) z_flag <= zero;
      if (state == S_WB) begin
        retired <= retired + 8'd1;
        pc      <= take_jump ? imm : pc + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: write-back events are scoreboarded,
// pc/state-visible outputs are checked at fixed cycles after reset release.
module tb_cpu_sequencer;

  typedef struct packed {
    logic [7:0] cyc;
    logic [3:0] pc;
    logic       we_a;
    logic       we_b;
    logic       do_alu;
    logic [2:0] alu_op;
    logic [3:0] imm;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] instr;
  logic       zero = 1'b0;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic [3:0] pc, imm;
  logic [2:0] alu_op;
  logic       do_alu, we_a, we_b, busy, halted;
  logic [7:0] retired;

  logic [7:0] imem [16];
  int compared = 0;
  int mismatched = 0;
  int cyc;
  ev_t exp_q[$];
  ev_t obs_q[$];

  cpu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .run(run), .step(step),
    .pc(pc), .imm(imm), .alu_op(alu_op), .do_alu(do_alu), .we_a(we_a), .we_b(we_b),
    .busy(busy), .halted(halted), .retired(retired)
  );

  assign instr = imem[pc];
  always #5 clk = ~clk;

  // cyc == k when sampled at the negedge following the k-th posedge after release
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  function automatic ev_t mk(input int c, input int p, input logic a, input logic b,
                             input logic d, input int op, input int im);
    ev_t e;
    e.cyc = 8'(c); e.pc = 4'(p); e.we_a = a; e.we_b = b;
    e.do_alu = d; e.alu_op = 3'(op); e.imm = 4'(im);
    return e;
  endfunction

  always @(negedge clk)
    if (rst_n && (we_a || we_b))
      obs_q.push_back(mk(cyc, int'(pc), we_a, we_b, do_alu, int'(alu_op), int'(imm)));

  task automatic clear_mem(input logic [7:0] fill);
    for (int i = 0; i < 16; i++) imem[i] = fill;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic do_reset(input logic run_at_release);
    @(negedge clk);
    rst_n = 1'b0; run = 1'b0; step = 1'b0;
    repeat (3) @(negedge clk);
    run = run_at_release;
    rst_n = 1'b1;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic test_reset;
    clear_mem(8'h13);
    @(negedge clk);
    rst_n = 1'b0; run = 1'b0; step = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if ({pc, imm, alu_op, do_alu, we_a, we_b, busy, halted, retired} !== 27'd0) begin
      mismatched++;
      $display("FAIL reset_values: pc=%0d imm=%0d alu_op=%0d do_alu=%b we_a=%b we_b=%b busy=%b halted=%b retired=%0d, required all 0",
               pc, imm, alu_op, do_alu, we_a, we_b, busy, halted, retired);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      compared++;
      if (busy !== 1'b0 || we_a !== 1'b0 || we_b !== 1'b0 || pc !== 4'd0 || retired !== 8'd0) begin
        mismatched++;
        $display("FAIL idle_hold cyc%0d: busy=%b we_a=%b we_b=%b pc=%0d retired=%0d, required 0", cyc, busy, we_a, we_b, pc, retired);
      end
    end
  endtask

  task automatic test_program;
    ev_t e, o;
    int hcyc;
    clear_mem(8'h00);
    imem[0] = 8'h13; imem[1] = 8'h25; imem[2] = 8'h33; imem[3] = 8'hF0;
    exp_q.push_back(mk(4, 0, 1'b1, 1'b0, 1'b0, 0, 3));
    exp_q.push_back(mk(8, 1, 1'b0, 1'b1, 1'b0, 0, 5));
    exp_q.push_back(mk(12, 2, 1'b1, 1'b0, 1'b1, 0, 3));
    do_reset(1'b1);
    for (int i = 0; i < 40 && !halted; i++) @(negedge clk);
    hcyc = halted ? cyc : -1;
    compared++;
    if (hcyc != 17) begin
      mismatched++;
      $display("FAIL prog_halt_cycle: got %0d, required 17", hcyc);
    end
    compared++;
    if (retired !== 8'd4 || pc !== 4'd4) begin
      mismatched++;
      $display("FAIL prog_final: retired=%0d pc=%0d, required retired=4 pc=4", retired, pc);
    end
    step = 1'b1;
    repeat (6) @(negedge clk);
    step = 1'b0;
    compared++;
    if (halted !== 1'b1 || busy !== 1'b0 || retired !== 8'd4) begin
      mismatched++;
      $display("FAIL halt_sticky: halted=%b busy=%b retired=%0d, required 1/0/4", halted, busy, retired);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compared++;
      if (obs_q.size() == 0) begin
        mismatched++;
        $display("FAIL prog_write: missing, required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          mismatched++;
          $display("FAIL prog_write: got %h, required %h", o, e);
        end
      end
    end
    compared++;
    if (obs_q.size() != 0) begin
      mismatched++;
      $display("FAIL prog_extra_writes: got %0d extra, required 0", obs_q.size());
    end
  endtask

  task automatic test_jz;
    ev_t e, o;
    int target;
    for (int k = 0; k < 2; k++) begin
      target = (k == 0) ? 9 : 3;
      clear_mem(8'h00);
      imem[0] = 8'h44; imem[1] = 8'h17; imem[2] = 8'h89; imem[target] = 8'hF0;
      exp_q.push_back(mk(4, 0, 1'b1, 1'b0, 1'b1, 1, 4));
      exp_q.push_back(mk(8, 1, 1'b1, 1'b0, 1'b0, 0, 7));
      zero = (k == 0);
      do_reset(1'b1);
      wait_cyc(2);
      compared++;
      if (alu_op !== 3'd1 || do_alu !== 1'b0) begin
        mismatched++;
        $display("FAIL jz_decode_ctrl: alu_op=%0d do_alu=%b, required 1/0", alu_op, do_alu);
      end
      wait_cyc(3);
      compared++;
      if (do_alu !== 1'b1) begin
        mismatched++;
        $display("FAIL jz_exec_do_alu: got %b, required 1", do_alu);
      end
      wait_cyc(4);
      zero = 1'b0;  // the LDA that follows must not disturb the latched flag
      wait_cyc(5);
      compared++;
      if (alu_op !== 3'd0) begin
        mismatched++;
        $display("FAIL jz_fetch_alu_op: got %0d, required 0", alu_op);
      end
      wait_cyc(13);
      compared++;
      if (pc !== 4'(target)) begin
        mismatched++;
        $display("FAIL jz_target k=%0d: pc=%0d, required %0d", k, pc, target);
      end
      for (int i = 0; i < 40 && !halted; i++) @(negedge clk);
      compared++;
      if (halted !== 1'b1 || pc !== 4'(target + 1) || retired !== 8'd4) begin
        mismatched++;
        $display("FAIL jz_halt k=%0d: halted=%b pc=%0d retired=%0d, required 1/%0d/4", k, halted, pc, retired, target + 1);
      end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compared++;
        if (obs_q.size() == 0) begin
          mismatched++;
          $display("FAIL jz_write: missing, required %h", e);
        end else begin
          o = obs_q.pop_front();
          if (o !== e) begin
            mismatched++;
            $display("FAIL jz_write: got %h, required %h", o, e);
          end
        end
      end
      compared++;
      if (obs_q.size() != 0) begin
        mismatched++;
        $display("FAIL jz_extra_writes: got %0d extra, required 0", obs_q.size());
      end
    end
  endtask

  task automatic test_step;
    ev_t e, o;
    clear_mem(8'h00);
    imem[0] = 8'h1A; imem[1] = 8'h2B;
    exp_q.push_back(mk(6, 0, 1'b1, 1'b0, 1'b0, 0, 10));
    exp_q.push_back(mk(14, 1, 1'b0, 1'b1, 1'b0, 0, 11));
    zero = 1'b0;
    do_reset(1'b0);
    wait_cyc(2);  step = 1'b1;
    wait_cyc(3);  step = 1'b0;
    compared++;
    if (busy !== 1'b1) begin
      mismatched++;
      $display("FAIL step_launch: busy=%b, required 1", busy);
    end
    wait_cyc(4);  step = 1'b1;  // edge while busy, must not queue
    wait_cyc(7);
    compared++;
    if (busy !== 1'b0 || retired !== 8'd1 || pc !== 4'd1) begin
      mismatched++;
      $display("FAIL step_one: busy=%b retired=%0d pc=%0d, required 0/1/1", busy, retired, pc);
    end
    wait_cyc(9);
    compared++;
    if (busy !== 1'b0 || retired !== 8'd1) begin
      mismatched++;
      $display("FAIL step_no_queue: busy=%b retired=%0d, required 0/1", busy, retired);
    end
    step = 1'b0;
    wait_cyc(10); step = 1'b1;
    wait_cyc(30);
    compared++;
    if (busy !== 1'b0 || retired !== 8'd2 || pc !== 4'd2) begin
      mismatched++;
      $display("FAIL step_held: busy=%b retired=%0d pc=%0d, required 0/2/2", busy, retired, pc);
    end
    step = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compared++;
      if (obs_q.size() == 0) begin
        mismatched++;
        $display("FAIL step_write: missing, required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          mismatched++;
          $display("FAIL step_write: got %h, required %h", o, e);
        end
      end
    end
    compared++;
    if (obs_q.size() != 0) begin
      mismatched++;
      $display("FAIL step_extra_writes: got %0d extra, required 0", obs_q.size());
    end
  endtask

  task automatic test_wrap_run_drop;
    clear_mem(8'h00);
    imem[0] = 8'h7E;
    do_reset(1'b1);
    wait_cyc(5);
    compared++;
    if (pc !== 4'd14) begin mismatched++; $display("FAIL wrap_jmp: pc=%0d, required 14", pc); end
    wait_cyc(9);
    compared++;
    if (pc !== 4'd15) begin mismatched++; $display("FAIL wrap_15: pc=%0d, required 15", pc); end
    wait_cyc(13);
    compared++;
    if (pc !== 4'd0) begin mismatched++; $display("FAIL wrap_0: pc=%0d, required 0", pc); end
    wait_cyc(14); run = 1'b0;
    wait_cyc(16);
    compared++;
    if (busy !== 1'b1) begin mismatched++; $display("FAIL drop_wb_busy: busy=%b, required 1", busy); end
    wait_cyc(17);
    compared++;
    if (busy !== 1'b0 || pc !== 4'd14 || retired !== 8'd4) begin
      mismatched++;
      $display("FAIL drop_idle: busy=%b pc=%0d retired=%0d, required 0/14/4", busy, pc, retired);
    end
    wait_cyc(22);
    compared++;
    if (busy !== 1'b0 || pc !== 4'd14 || retired !== 8'd4 || obs_q.size() != 0) begin
      mismatched++;
      $display("FAIL drop_stays_idle: busy=%b pc=%0d retired=%0d writes=%0d, required 0/14/4/0", busy, pc, retired, obs_q.size());
    end
  endtask

  task automatic test_reset_mid;
    ev_t e, o;
    clear_mem(8'h00);
    imem[0] = 8'h44; imem[1] = 8'h33;
    exp_q.push_back(mk(4, 0, 1'b1, 1'b0, 1'b1, 1, 4));
    zero = 1'b1;
    do_reset(1'b1);
    wait_cyc(7);
    rst_n = 1'b0;
    #1;
    compared++;
    if (we_a !== 1'b0 || do_alu !== 1'b0 || pc !== 4'd0 || busy !== 1'b0 || retired !== 8'd0) begin
      mismatched++;
      $display("FAIL rst_mid: we_a=%b do_alu=%b pc=%0d busy=%b retired=%0d, required 0/0/0/0/0", we_a, do_alu, pc, busy, retired);
    end
    repeat (3) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compared++;
      if (obs_q.size() == 0) begin
        mismatched++;
        $display("FAIL rst_mid_write: missing, required %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          mismatched++;
          $display("FAIL rst_mid_write: got %h, required %h", o, e);
        end
      end
    end
    compared++;
    if (obs_q.size() != 0) begin
      mismatched++;
      $display("FAIL rst_mid_extra_writes: got %0d extra, required 0", obs_q.size());
    end
    // z_flag was 1 before reset; a JZ right after reset must fall through
    clear_mem(8'h00);
    imem[0] = 8'h85; imem[1] = 8'hF0; imem[5] = 8'hF0;
    zero = 1'b0;
    run = 1'b1;
    rst_n = 1'b1;
    wait_cyc(5);
    compared++;
    if (pc !== 4'd1) begin
      mismatched++;
      $display("FAIL rst_clears_z: pc=%0d, required 1", pc);
    end
    run = 1'b0;
  endtask

  initial begin
    test_reset;
    test_program;
    test_jz;
    test_step;
    test_wrap_run_drop;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control sequencer for the mini CPU datapath. It replaces single-cycle decode with a 4-state fetch/decode/execute/writeback FSM, and owns the program counter and the latched zero flag. It drives register-file write enables, the ALU opcode and the writeback-source select. A run/step debug handshake lets a bench or host free-run, single-step or halt the core.

## Interface
- No parameters; widths fixed: PC 4 bits, instruction 8 bits, ALU opcode 3 bits.
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- instr  input  8  instruction memory read data for address `pc`; [7:4] opcode, [3:0] imm.
- zero  input  1  ALU zero output, combinational from current operands.
- run  input  1  level; high = free-run instructions back to back.
- step  input  1  rising edge in IDLE executes exactly one instruction.
- pc  output  4  program counter (instruction memory address).
- imm  output  4  IR[3:0], immediate for writeback path.
- alu_op  output  3  ALU operation code.
- do_alu  output  1  writeback source: 1 = ALU result, 0 = {4'd0, imm}.
- we_a, we_b  output  1 each  register A/B write enables, one-cycle pulses.
- busy  output  1  high in FETCH/DECODE/EXEC/WB.
- halted  output  1  high in HALTED.
- retired  output  8  retired-instruction count, wraps 255→0.

## Operation
- Opcodes:
  - 0x0 NOP.
  - 0x1 LDA (A←imm).
  - 0x2 LDB (B←imm).
  - 0x3 ADD, 0x4 SUB, 0x5 AND, 0x6 OR: A←ALU, with alu_op = 000/001/010/011 respectively.
  - 0x7 JMP (pc←imm).
  - 0x8 JZ (pc←imm if z_flag else pc+1).
  - 0xF HLT.
  - All other codes execute as NOP.
- States: IDLE, FETCH, DECODE, EXEC, WB, HALTED.
- IDLE:
  - run=1 → FETCH.
  - Otherwise, step rising edge (step=1 and step_d=0) → FETCH with single-step flag set.
  - run has priority when both are present.
- FETCH → DECODE: IR←instr at end of FETCH.
- DECODE → EXEC.
- EXEC → WB:
  - alu_op valid from DECODE through WB; alu_op=000 for non-ALU opcodes.
  - For ALU opcodes, z_flag←zero at end of EXEC.
  - For other opcodes, z_flag is unchanged.
- WB:
  - we_a=1 for LDA and ALU ops; we_b=1 for LDB; no write for other opcodes.
  - do_alu=1 for ALU ops in EXEC and WB, else 0.
  - pc update at end of WB: jump target for JMP and for taken JZ; otherwise pc+1 mod 16 (15→0).
  - retired increments at end of WB, including for HLT.
- WB exit:
  - HLT → HALTED.
  - Else if run=1 and single-step flag clear → FETCH.
  - Else → IDLE, clearing the single-step flag.
- HALTED: sticky; run and step are ignored; exit only by reset. pc is left at HLT address +1.
- run falling mid-instruction: the current instruction completes through WB, then the FSM goes to IDLE.
- A step edge while busy is ignored (not queued). step_d is sampled every cycle.
- Reset mid-instruction: immediately abandons the instruction; no write-enable pulse survives past reset assertion.

## Timing
- Reset values:
  - State IDLE.
  - pc=0, IR=0 (so imm=0), z_flag=0, retired=0, step_d=0.
  - we_a=we_b=0, do_alu=0, alu_op=000, busy=0, halted=0.
- Outputs we_a, we_b, do_alu, alu_op, busy and halted are Moore decodes of state and IR; no dependence on instr in the same cycle.
- Instruction latency: exactly 4 cycles (FETCH, DECODE, EXEC, WB).
- Free-run throughput: one instruction per 4 cycles.
- Step edge sampled in IDLE at edge N:
  - FETCH in cycle N+1.
  - WB in cycle N+4.
  - IDLE in cycle N+5.
- Write pulses and pc are registered on the same edge: registers written and pc advanced at the end of WB.
- JZ reads z_flag as latched by the most recent ALU instruction's EXEC.

## Test plan
- Reset: hold rst_n=0 three cycles, release with run=0 → pc=0, busy=0, halted=0, retired=0, all enables 0, stays IDLE for 10 cycles.
- Program 0x13, 0x25, 0x33, 0xF0 with run=1:
  - we_a pulses in WB of instr 0 (do_alu=0, imm=3).
  - we_b pulses in WB of instr 1 (imm=5).
  - we_a with do_alu=1 and alu_op=000 in WB of instr 2.
  - halted=1 from cycle 17 after release.
  - retired=4, pc=4.
- JZ: SUB of equal operands (zero=1 in EXEC), then 0x89 → pc=9. Repeat with zero=0 → pc = JZ address+1.
- Step mode with run=0:
  - One step pulse → exactly one we pulse, retired=1, back to IDLE.
  - Step held high for 20 cycles → still one instruction.
- Wrap and run drop:
  - NOPs from pc=14 → pc goes 15 then 0.
  - Drop run during DECODE → WB still occurs, then IDLE with busy=0.
- Reset asserted during EXEC of ADD → no we_a pulse, pc=0, state IDLE, z_flag=0.
